// File: rtl/sa_pkg.sv
// Shared types for the systolic-array layer sequencer: the FSM state
// encoding, the per-layer configuration record and the operation selectors.
package sa_pkg;

    // Width of the rows / result-count fields carried in a layer command.
    localparam int SA_CNT_W = 10;

    // op_sel encoding: which SA result strobe marks a finished beat.
    localparam logic OP_CONV = 1'b0;
    localparam logic OP_MUL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CFG     = 3'd1,
        WB_REQ  = 3'd2,
        WB_WAIT = 3'd3,
        STREAM  = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic                op_sel;
        logic                relu_sel;
        logic                sign_en;
        logic [3:0]          w_width;
        logic [3:0]          w_height;
        logic [3:0]          mul_b_w;
        logic [3:0]          mul_b_h;
        logic [3:0]          ifmap_i_w;
        logic [SA_CNT_W-1:0] rows;
        logic [SA_CNT_W-1:0] res_cnt;
    } layer_cfg_t;

endpackage

// File: rtl/sa_seq_watchdog.sv
// Stall watchdog for the layer sequencer: counts consecutive cycles spent
// waiting without progress and flags expiry on the LIMIT-th such cycle.
module sa_seq_watchdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic nrst,
    input  logic active,
    input  logic progress,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] stall_cnt_reg;

    // Expiry fires during the cycle that would be the LIMIT-th stalled one.
    assign expire = active && !progress && (stall_cnt_reg == CW'(LIMIT - 1));

    // Stall counter: cleared on progress or when not waiting, saturating otherwise.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt_reg <= '0;
        end else if (!active || progress) begin
            stall_cnt_reg <= '0;
        end else if (stall_cnt_reg != {CW{1'b1}}) begin
            stall_cnt_reg <= stall_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/sa_layer_sequencer.sv
// Per-layer controller in front of the systolic-array compute top.
// Accepts a layer command, pulses the layer-info load, fetches weights and
// biases, streams ifmap beats into the array and counts result beats.
// Optional build macro SA_SEQ_TIMEOUT_EN adds a stall watchdog on the
// WB_WAIT and DRAIN states that aborts the layer with an err pulse.
module sa_layer_sequencer
    import sa_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  layer_cfg_t                  cmd_cfg,
    output logic                        wb_req,
    input  logic                        wb_valid,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic [WIDTH*DATA_WIDTH-1:0] src_data,
    output logic                        sa_load_layer_info,
    output layer_cfg_t                  sa_cfg,
    output logic                        sa_weight_iv,
    output logic                        sa_b_iv,
    output logic                        sa_data_iv,
    output logic [WIDTH*DATA_WIDTH-1:0] sa_data_id,
    input  logic                        sa_conv_ov,
    input  logic                        sa_mul_ov,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    seq_state_t state_reg;
    seq_state_t state_next;

    logic       cmd_ready_reg;
    logic       busy_reg;
    logic       load_reg;
    logic       wb_req_reg;
    logic       src_ready_reg;
    logic       done_reg;
    logic       err_reg;
    layer_cfg_t cfg_reg;

    logic [CNT_W-1:0] row_cnt_reg;
    logic [CNT_W-1:0] res_cnt_reg;
    logic [CNT_W-1:0] rows_tgt;
    logic [CNT_W-1:0] res_tgt;

    logic                        data_iv_reg;
    logic [WIDTH*DATA_WIDTH-1:0] data_id_reg;

    logic cmd_accept;
    logic beat_acc;
    logic last_row;
    logic res_strobe;
    logic res_hit;
    logic wd_active;
    logic wd_progress;
    logic wd_expire;

    assign rows_tgt   = CNT_W'(cfg_reg.rows);
    assign res_tgt    = CNT_W'(cfg_reg.res_cnt);
    assign cmd_accept = cmd_ready_reg && cmd_valid;
    assign beat_acc   = src_ready_reg && src_valid;
    assign last_row   = (row_cnt_reg == rows_tgt - CNT_W'(1));
    assign res_strobe = (cfg_reg.op_sel == OP_MUL) ? sa_mul_ov : sa_conv_ov;

    // A result only counts while the layer is streaming or draining, and
    // only up to the configured target; surplus strobes are dropped.
    assign res_hit = ((state_reg == STREAM) || (state_reg == DRAIN)) && res_strobe
                     && (res_cnt_reg != res_tgt) && (res_cnt_reg != {CNT_W{1'b1}});

    assign wd_active   = (state_reg == WB_WAIT) || (state_reg == DRAIN);
    assign wd_progress = ((state_reg == WB_WAIT) && wb_valid) || res_hit;

`ifdef SA_SEQ_TIMEOUT_EN
    sa_seq_watchdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .nrst    (nrst),
        .active  (wd_active),
        .progress(wd_progress),
        .expire  (wd_expire)
    );

    logic unused_params;
    assign unused_params = (HEIGHT > 0);
`else
    assign wd_expire = 1'b0;

    logic unused_params;
    assign unused_params = (HEIGHT > 0) ^ (TIMEOUT_CYC > 0) ^ wd_active ^ wd_progress;
`endif

    // Next-state decode for the layer FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_accept) state_next = CFG;
            CFG:     state_next = WB_REQ;
            WB_REQ:  state_next = WB_WAIT;
            WB_WAIT: begin
                if (wd_expire) begin
                    state_next = IDLE;
                end else if (wb_valid) begin
                    state_next = (rows_tgt == '0) ? DRAIN : STREAM;
                end
            end
            STREAM:  if (beat_acc && last_row) state_next = DRAIN;
            DRAIN: begin
                if (wd_expire) begin
                    state_next = IDLE;
                end else if (res_cnt_reg == res_tgt) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state, registered control outputs and the latched layer config.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            load_reg      <= 1'b0;
            wb_req_reg    <= 1'b0;
            src_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cfg_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == IDLE);
            busy_reg      <= (state_next != IDLE);
            load_reg      <= (state_next == CFG);
            wb_req_reg    <= (state_next == WB_REQ);
            src_ready_reg <= (state_next == STREAM);
            done_reg      <= (state_next == DONE);
            err_reg       <= wd_expire;
            if (cmd_accept) begin
                cfg_reg <= cmd_cfg;
            end
        end
    end

    // Row / result counters and the registered ifmap beat toward the array.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            row_cnt_reg <= '0;
            res_cnt_reg <= '0;
            data_iv_reg <= 1'b0;
            data_id_reg <= '0;
        end else begin
            data_iv_reg <= beat_acc;
            if (beat_acc) begin
                data_id_reg <= src_data;
            end
            if (cmd_accept) begin
                row_cnt_reg <= '0;
                res_cnt_reg <= '0;
            end else begin
                if (beat_acc && (row_cnt_reg != {CNT_W{1'b1}})) begin
                    row_cnt_reg <= row_cnt_reg + CNT_W'(1);
                end
                if (res_hit) begin
                    res_cnt_reg <= res_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign cmd_ready          = cmd_ready_reg;
    assign busy               = busy_reg;
    assign sa_load_layer_info = load_reg;
    assign wb_req             = wb_req_reg;
    assign src_ready          = src_ready_reg;
    assign done               = done_reg;
    assign err                = err_reg;
    assign sa_cfg             = cfg_reg;
    assign sa_data_iv         = data_iv_reg;
    assign sa_data_id         = data_id_reg;

    // Weight/bias valids follow the buffer bus only while the fetch is pending.
    assign sa_weight_iv = wb_valid && (state_reg == WB_WAIT);
    assign sa_b_iv      = wb_valid && (state_reg == WB_WAIT);

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// Self-checking bench for sa_layer_sequencer: drives layer commands, keeps a
// scoreboard of accepted ifmap beats and checks cycle-level control timing.
module tb_sa_layer_sequencer;
    import sa_pkg::*;

    localparam int WIDTH       = 8;
    localparam int HEIGHT      = 8;
    localparam int DATA_WIDTH  = 8;
    localparam int CNT_W       = 10;
    localparam int TIMEOUT_CYC = 16;
    localparam int DW          = WIDTH * DATA_WIDTH;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    layer_cfg_t    cmd_cfg = '0;
    logic          wb_req;
    logic          wb_valid = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] src_data = '0;
    logic          sa_load_layer_info;
    layer_cfg_t    sa_cfg;
    logic          sa_weight_iv;
    logic          sa_b_iv;
    logic          sa_data_iv;
    logic [DW-1:0] sa_data_id;
    logic          sa_conv_ov = 1'b0;
    logic          sa_mul_ov = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    sa_layer_sequencer #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_cfg           (cmd_cfg),
        .wb_req            (wb_req),
        .wb_valid          (wb_valid),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_data          (src_data),
        .sa_load_layer_info(sa_load_layer_info),
        .sa_cfg            (sa_cfg),
        .sa_weight_iv      (sa_weight_iv),
        .sa_b_iv           (sa_b_iv),
        .sa_data_iv        (sa_data_iv),
        .sa_data_id        (sa_data_id),
        .sa_conv_ov        (sa_conv_ov),
        .sa_mul_ov         (sa_mul_ov),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            done_seen = 0;
    int            beats_seen = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic op, input logic good, input logic bad);
        if (op == OP_MUL) begin
            sa_mul_ov  = good;
            sa_conv_ov = bad;
        end else begin
            sa_conv_ov = good;
            sa_mul_ov  = bad;
        end
    endtask

    function automatic layer_cfg_t make_cfg(input logic op, input int rows, input int res);
        layer_cfg_t c;
        c           = '0;
        c.op_sel    = op;
        c.relu_sel  = 1'b1;
        c.sign_en   = op;
        c.w_width   = 4'h8;
        c.w_height  = 4'h7;
        c.mul_b_w   = 4'h2;
        c.mul_b_h   = 4'h3;
        c.ifmap_i_w = 4'h5;
        c.rows      = SA_CNT_W'(rows);
        c.res_cnt   = SA_CNT_W'(res);
        return c;
    endfunction

    // Scoreboard monitor: every presented beat must match the oldest driven one.
    always @(negedge clk) begin
        if (sa_data_iv) begin
            if (exp_q.size() == 0) begin
                check_val("data_iv_spurious", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("data_beat", sa_data_id, mon_exp);
            end
            beats_seen++;
        end
        if (done) done_seen++;
    end

    // One complete layer: command, fetch, stream (optional), drain, done.
    task automatic run_layer(input string name, input layer_cfg_t c, input int wb_delay,
                             input bit toggle, input int early);
        int iters;
        int late;
        check_val({name, "_idle_ready"}, cmd_ready, 1);
        cmd_cfg   = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_val({name, "_load"}, sa_load_layer_info, 1);
        check_val({name, "_cfg"}, sa_cfg, c);
        check_val({name, "_busy"}, busy, 1);
        check_val({name, "_ready_busy"}, cmd_ready, 0);
        check_val({name, "_wbreq_early"}, wb_req, 0);
        step();
        check_val({name, "_wbreq"}, wb_req, 1);
        check_val({name, "_load_once"}, sa_load_layer_info, 0);
        step();
        check_val({name, "_wbreq_once"}, wb_req, 0);
        for (int i = 0; i < wb_delay - 1; i++) begin
            set_res(c.op_sel, 1'b1, 1'b1);
            check_val({name, "_weight_iv_wait"}, sa_weight_iv, 0);
            step();
        end
        set_res(c.op_sel, 1'b0, 1'b0);
        wb_valid = 1'b1;
        #1;
        check_val({name, "_weight_iv"}, sa_weight_iv, 1);
        check_val({name, "_b_iv"}, sa_b_iv, 1);
        step();
        wb_valid = 1'b0;
        if (c.rows == 0) begin
            check_val({name, "_no_src_ready"}, src_ready, 0);
            late = int'(c.res_cnt);
        end else begin
            check_val({name, "_src_ready"}, src_ready, 1);
            iters = toggle ? 2 * int'(c.rows) - 1 : int'(c.rows);
            for (int i = 0; i < iters; i++) begin
                src_valid = toggle ? (i % 2 == 0) : 1'b1;
                src_data  = {$urandom, $urandom};
                if (src_valid) exp_q.push_back(src_data);
                set_res(c.op_sel, i < early, 1'b1);
                step();
            end
            src_valid = 1'b0;
            set_res(c.op_sel, 1'b0, 1'b0);
            check_val({name, "_src_ready_drain"}, src_ready, 0);
            late = (int'(c.res_cnt) > early) ? int'(c.res_cnt) - early : 0;
        end
        if (late > 0) begin
            for (int i = 0; i < 2; i++) begin
                set_res(c.op_sel, 1'b0, 1'b1);
                check_val({name, "_done_wrong_strobe"}, done, 0);
                step();
            end
            for (int i = 0; i < late; i++) begin
                set_res(c.op_sel, 1'b1, 1'b0);
                check_val({name, "_done_counting"}, done, 0);
                step();
            end
            set_res(c.op_sel, 1'b0, 1'b0);
        end
        check_val({name, "_done_drain"}, done, 0);
        step();
        check_val({name, "_done"}, done, 1);
        check_val({name, "_busy_done"}, busy, 1);
        step();
        check_val({name, "_done_once"}, done, 0);
        check_val({name, "_busy_idle"}, busy, 0);
        check_val({name, "_ready_after"}, cmd_ready, 1);
        check_val({name, "_sb_empty"}, exp_q.size(), 0);
        $display("layer %s: rows=%0d res=%0d op=%0d complete", name, c.rows, c.res_cnt, c.op_sel);
    endtask

    initial begin
        layer_cfg_t ca;
        layer_cfg_t cb;
        layer_cfg_t c5;

        // Reset state
        repeat (3) step();
        nrst = 1'b1;
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_load", sa_load_layer_info, 0);
        check_val("rst_wb_req", wb_req, 0);
        check_val("rst_src_ready", src_ready, 0);
        check_val("rst_data_iv", sa_data_iv, 0);
        check_val("rst_sa_cfg", sa_cfg, 0);

        // 1: CONV layer, weights three cycles after the request
        run_layer("t1_conv", make_cfg(OP_CONV, 4, 4), 3, 1'b0, 0);
        check_val("t1_beats", beats_seen, 4);

        // 2: MUL layer with gapped source and surplus results during STREAM
        run_layer("t2_mul", make_cfg(OP_MUL, 8, 1), 1, 1'b1, 3);
        check_val("t2_beats", beats_seen, 12);

        // 3: empty layer
        run_layer("t3_empty", make_cfg(OP_CONV, 0, 0), 2, 1'b0, 0);
        check_val("t3_beats", beats_seen, 12);

        // 4: command held during a busy layer
        ca = make_cfg(OP_CONV, 0, 0);
        ca.w_width = 4'h3;
        cb = make_cfg(OP_MUL, 0, 0);
        cb.w_height = 4'h5;
        cmd_cfg   = ca;
        cmd_valid = 1'b1;
        step();
        cmd_cfg = cb;
        check_val("t4_ready_cfg", cmd_ready, 0);
        check_val("t4_cfg_a", sa_cfg, ca);
        step();
        check_val("t4_ready_wbreq", cmd_ready, 0);
        step();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        check_val("t4_ready_drain", cmd_ready, 0);
        check_val("t4_cfg_a_hold", sa_cfg, ca);
        step();
        check_val("t4_done_a", done, 1);
        check_val("t4_ready_done", cmd_ready, 0);
        step();
        check_val("t4_ready_idle", cmd_ready, 1);
        check_val("t4_cfg_a_idle", sa_cfg, ca);
        check_val("t4_no_load", sa_load_layer_info, 0);
        step();
        cmd_valid = 1'b0;
        check_val("t4_load_b", sa_load_layer_info, 1);
        check_val("t4_cfg_b", sa_cfg, cb);
        step();
        step();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        step();
        check_val("t4_done_b", done, 1);
        step();
        check_val("t4_ready_end", cmd_ready, 1);
        $display("layer t4: back-to-back commands complete");

        // 5: reset mid-stream after two beats
        c5 = make_cfg(OP_CONV, 6, 2);
        cmd_cfg   = c5;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'b1;
            src_data  = {$urandom, $urandom};
            exp_q.push_back(src_data);
            step();
        end
        src_data = {$urandom, $urandom};
        nrst = 1'b0;
        step();
        nrst      = 1'b1;
        src_valid = 1'b0;
        check_val("t5_ready", cmd_ready, 1);
        check_val("t5_busy", busy, 0);
        check_val("t5_src_ready", src_ready, 0);
        check_val("t5_data_iv", sa_data_iv, 0);
        check_val("t5_sa_cfg", sa_cfg, 0);
        check_val("t5_done", done, 0);
        step();
        check_val("t5_done_after", done, 0);
        check_val("t5_sb_empty", exp_q.size(), 0);
        check_val("t5_beats", beats_seen, 14);
        $display("layer t5: aborted by reset");
        run_layer("t5_after", make_cfg(OP_CONV, 2, 2), 1, 1'b0, 1);
        check_val("t5_after_beats", beats_seen, 16);

`ifdef SA_SEQ_TIMEOUT_EN
        // 6: watchdog expiry while waiting for weights
        cmd_cfg   = make_cfg(OP_CONV, 1, 1);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        for (int i = 1; i <= TIMEOUT_CYC; i++) begin
            check_val("t6_err_wait", err, 0);
            check_val("t6_busy_wait", busy, 1);
            step();
        end
        check_val("t6_err", err, 1);
        check_val("t6_ready", cmd_ready, 1);
        check_val("t6_busy", busy, 0);
        check_val("t6_done", done, 0);
        step();
        check_val("t6_err_once", err, 0);
        $display("layer t6: watchdog abort");
`endif

        step();
        check_val("done_pulses", done_seen, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
